// File: rtl/radix3_bf_pipe.sv
// Three-stage pipelined radix-3 DFT butterfly with a 0..8 output triplet label.
// Define RADIX3_BF_ROUND_EN to round half up in the final divide-by-4 (default: floor).
module radix3_bf_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        dout_valid,
  output logic [31:0] X0,
  output logic [31:0] X1,
  output logic [31:0] X2,
  output logic [3:0]  dout_idx,
  output logic        dout_last
);

  // sqrt(3)/2 in Q1.15
  localparam logic signed [15:0] K_SIN = 16'sd28378;
`ifdef RADIX3_BF_ROUND_EN
  localparam logic [18:0] RND = 19'd2;
`else
  localparam logic [18:0] RND = 19'd0;
`endif

  logic        v1, v2;
  logic [15:0] a1_r, a1_i;
  logic [16:0] s1_r, s1_i, d1_r, d1_i;
  logic [17:0] sum_r, sum_i, t_r, t_i, m_r, m_i;
  logic [3:0]  cnt;

  logic signed [32:0] prod_r, prod_i;
  logic [18:0] x0_r, x0_i, x1_r, x1_i, x2_r, x2_i;
  logic        unused_bits;

  // NOTE: datapath registers carry no reset; only the valid/label state and the
  // visible outputs are cleared, and data only loads behind its stage valid.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      a1_r <= a[31:16];
      a1_i <= a[15:0];
      s1_r <= {b[31], b[31:16]} + {c[31], c[31:16]};
      s1_i <= {b[15], b[15:0]}  + {c[15], c[15:0]};
      d1_r <= {b[31], b[31:16]} - {c[31], c[31:16]};
      d1_i <= {b[15], b[15:0]}  - {c[15], c[15:0]};
    end
  end

  assign prod_r = $signed(d1_r) * K_SIN;
  assign prod_i = $signed(d1_i) * K_SIN;

  always_ff @(posedge clk) begin
    if (v1) begin
      sum_r <= {{2{a1_r[15]}}, a1_r} + {s1_r[16], s1_r};
      sum_i <= {{2{a1_i[15]}}, a1_i} + {s1_i[16], s1_i};
      t_r   <= {{2{a1_r[15]}}, a1_r} - {{2{s1_r[16]}}, s1_r[16:1]};
      t_i   <= {{2{a1_i[15]}}, a1_i} - {{2{s1_i[16]}}, s1_i[16:1]};
      // >>>15 of the product is just its upper slice; floor comes for free
      m_r   <= prod_r[32:15];
      m_i   <= prod_i[32:15];
    end
  end

  // One extra bit so t +/- m (up to ~122k in magnitude) cannot wrap
  assign x0_r = {sum_r[17], sum_r} + RND;
  assign x0_i = {sum_i[17], sum_i} + RND;
  assign x1_r = {t_r[17], t_r} + {m_i[17], m_i} + RND;
  assign x1_i = {t_i[17], t_i} - {m_r[17], m_r} + RND;
  assign x2_r = {t_r[17], t_r} - {m_i[17], m_i} + RND;
  assign x2_i = {t_i[17], t_i} + {m_r[17], m_r} + RND;

  assign unused_bits = ^{prod_r[14:0], prod_i[14:0],
                         x0_r[18], x0_r[1:0], x0_i[18], x0_i[1:0],
                         x1_r[18], x1_r[1:0], x1_i[18], x1_i[1:0],
                         x2_r[18], x2_r[1:0], x2_i[18], x2_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_idx   <= 4'd0;
      cnt        <= 4'd0;
      X0         <= '0;
      X1         <= '0;
      X2         <= '0;
    end else begin
      v1         <= din_valid;
      v2         <= v1;
      dout_valid <= v2;
      dout_last  <= v2 && (cnt == 4'd8);
      if (v2) begin
        // divide by 4 and truncate to 16 bits in one slice
        X0       <= {x0_r[17:2], x0_i[17:2]};
        X1       <= {x1_r[17:2], x1_i[17:2]};
        X2       <= {x2_r[17:2], x2_i[17:2]};
        dout_idx <= cnt;
        cnt      <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
      end
    end
  end

endmodule
